// File: rtl/amm_ram_slave.sv
// Avalon-MM style RAM slave: fixed wait states, fixed read latency, one
// transaction in flight, out-of-range accesses counted and answered with OOR_RDATA.
module amm_ram_slave #(
  parameter int                 ADDR_W       = 32,
  parameter int                 DATA_W       = 32,
  parameter int                 MEM_BYTES    = 2048,
  parameter int                 WAIT_STATES  = 1,
  parameter int                 READ_LATENCY = 2,
  parameter logic [DATA_W-1:0]  OOR_RDATA    = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic [DATA_W/8-1:0] i_byteenable,
  input  logic                i_read,
  input  logic                i_write,
  input  logic [DATA_W-1:0]   i_writedata,
  output logic                o_waitrequest,
  output logic [DATA_W-1:0]   o_readdata,
  output logic                o_readdatavalid,
  output logic [15:0]         o_oor_cnt
);

  localparam int BE_W  = DATA_W / 8;
  localparam int WORDS = MEM_BYTES / BE_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, RDLAT} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [3:0]          r_waitCnt;
  logic [3:0]          w_nextWaitCnt;
  logic [2:0]          r_latCnt;
  logic [2:0]          w_nextLatCnt;
  logic                w_nextWaitReq;
  logic                w_nextValid;
  logic                w_accept;
  logic                w_commit;
  logic [DATA_W-1:0]   w_rdWord;

  logic                r_isWrite;
  logic                r_oor;
  logic [IDX_W-1:0]    r_wordIdx;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_mem [WORDS];

  assign w_accept = (r_state == IDLE) && (i_read || i_write);
  assign w_commit = (r_state == ACK) && r_isWrite && !r_oor;
  assign w_rdWord = r_oor ? OOR_RDATA : r_mem[r_wordIdx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_waitCnt <= '0;
      r_latCnt  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
      r_latCnt  <= w_nextLatCnt;
    end
  end

  // The wait counter is loaded with WAIT_STATES and ACK follows the cycle in
  // which it reaches zero; the latency counter marks the final RDLAT cycle.
  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    w_nextLatCnt  = r_latCnt;
    unique case (r_state)
      IDLE: begin
        if (i_read || i_write) begin
          if (WAIT_STATES == 0) begin
            w_nextState = ACK;
          end else begin
            w_nextState   = WAIT;
            w_nextWaitCnt = 4'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        w_nextWaitCnt = r_waitCnt - 4'd1;
        if (w_nextWaitCnt == 4'd0) begin
          w_nextState = ACK;
        end
      end
      ACK: begin
        if (r_isWrite) begin
          w_nextState = IDLE;
        end else begin
          w_nextState  = RDLAT;
          w_nextLatCnt = 3'(READ_LATENCY - 1);
        end
      end
      RDLAT: begin
        if (r_latCnt == 3'd0) begin
          w_nextState = IDLE;
        end else begin
          w_nextLatCnt = r_latCnt - 3'd1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_nextWaitReq = 1'b1;
    w_nextValid   = 1'b0;
    if (w_nextState == ACK) begin
      w_nextWaitReq = 1'b0;
    end
    if ((w_nextState == RDLAT) && (w_nextLatCnt == 3'd0)) begin
      w_nextValid = 1'b1;
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_waitrequest   <= 1'b1;
      o_readdatavalid <= 1'b0;
      o_readdata      <= '0;
      o_oor_cnt       <= '0;
      r_isWrite       <= 1'b0;
      r_oor           <= 1'b0;
      r_wordIdx       <= '0;
      r_be            <= '0;
      r_wdata         <= '0;
    end else begin
      o_waitrequest   <= w_nextWaitReq;
      o_readdatavalid <= w_nextValid;
      if (w_nextValid) begin
        o_readdata <= w_rdWord;
      end
      if ((r_state == ACK) && r_oor && (o_oor_cnt != 16'hFFFF)) begin
        o_oor_cnt <= o_oor_cnt + 16'd1;
      end
      if (w_accept) begin
        r_isWrite <= i_write;
        r_oor     <= (i_address >= ADDR_W'(MEM_BYTES));
        r_wordIdx <= i_address[OFF_W +: IDX_W];
        r_be      <= i_byteenable;
        r_wdata   <= i_writedata;
      end
    end
  end

  // Backing RAM deliberately has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < BE_W; b++) begin
        if (r_be[b]) begin
          r_mem[r_wordIdx][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_amm_ram_slave.sv
// Directed bench for amm_ram_slave: default instance plus two timing variants
// (WAIT_STATES/READ_LATENCY = 0/1 and 3/4) sharing address and data lines.
module tb_amm_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  int          cycle = 0;
  logic        rd0 = 1'b0, wr0 = 1'b0, rdS = 1'b0, wrS = 1'b0;
  logic [31:0] addrIn = '0, dataIn = '0;
  logic [3:0]  beIn = '0;
  logic [2:0]  wrq, vld;
  logic [31:0] rdat0, rdat1, rdat2;
  logic [15:0] oor0, oor1, oor2;

  int          ackEdge [3];
  int          vldEdge [3];
  int          ackCnt  [3];
  int          vldCnt  [3];
  logic [31:0] vldData [3];
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  amm_ram_slave dut0 (
    .clk(clk), .rst(rst), .i_address(addrIn), .i_byteenable(beIn),
    .i_read(rd0), .i_write(wr0), .i_writedata(dataIn),
    .o_waitrequest(wrq[0]), .o_readdata(rdat0), .o_readdatavalid(vld[0]), .o_oor_cnt(oor0));

  amm_ram_slave #(.WAIT_STATES(0), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .i_address(addrIn), .i_byteenable(beIn),
    .i_read(rdS), .i_write(wrS), .i_writedata(dataIn),
    .o_waitrequest(wrq[1]), .o_readdata(rdat1), .o_readdatavalid(vld[1]), .o_oor_cnt(oor1));

  amm_ram_slave #(.WAIT_STATES(3), .READ_LATENCY(4)) dut2 (
    .clk(clk), .rst(rst), .i_address(addrIn), .i_byteenable(beIn),
    .i_read(rdS), .i_write(wrS), .i_writedata(dataIn),
    .o_waitrequest(wrq[2]), .o_readdata(rdat2), .o_readdatavalid(vld[2]), .o_oor_cnt(oor2));

  // A value seen at a negedge is what the following posedge (cycle+1) samples.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst && (wrq[i] == 1'b0)) begin
        ackEdge[i] = cycle + 1;
        ackCnt[i]  = ackCnt[i] + 1;
      end
      if (vld[i] === 1'b1) begin
        vldEdge[i] = cycle + 1;
        vldCnt[i]  = vldCnt[i] + 1;
        vldData[i] = (i == 0) ? rdat0 : ((i == 1) ? rdat1 : rdat2);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] pat(input int i);
    return {16'hBEE0 + 16'(i), 16'(i) ^ 16'h5A5A};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clearMon();
    for (int i = 0; i < 3; i++) begin
      ackEdge[i] = -100; vldEdge[i] = -100; ackCnt[i] = 0; vldCnt[i] = 0; vldData[i] = 'x;
    end
  endtask

  // Holds the request on dut0 until waitrequest is seen low, then drops it.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] data, output int kEdge);
    bit done;
    done = 1'b0;
    @(negedge clk);
    rd0 = rd; wr0 = wr; addrIn = addr; beIn = be; dataIn = data;
    kEdge = cycle + 1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (wrq[0] == 1'b0) done = 1'b1;
    end
    @(posedge clk);
    #1;
    rd0 = 1'b0; wr0 = 1'b0;
    checkOutput("ack_seen", 32'(done), 32'd1);
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data, output int kEdge);
    clearMon();
    applyStimulus(1'b0, 1'b1, addr, be, data, kEdge);
    repeat (2) @(negedge clk);
  endtask

  task automatic doRead(input logic [31:0] addr, output logic [31:0] data, output int kEdge);
    clearMon();
    applyStimulus(1'b1, 1'b0, addr, 4'h0, 32'h0, kEdge);
    for (int i = 0; i < 30 && vldCnt[0] == 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    data = vldData[0];
  endtask

  task automatic checkRead(input string tag, input logic [31:0] addr, input logic [31:0] expected);
    logic [31:0] d;
    int          k;
    doRead(addr, d, k);
    checkOutput({tag, "_data"}, d, expected);
    checkOutput({tag, "_vcnt"}, 32'(vldCnt[0]), 32'd1);
  endtask

  task automatic pulseSweep(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, output int kEdge);
    clearMon();
    @(negedge clk);
    rdS = rd; wrS = wr; addrIn = addr; dataIn = data; beIn = 4'hF;
    kEdge = cycle + 1;
    @(negedge clk);
    rdS = 1'b0; wrS = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    int          k;
    int          idx;
    clearMon();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset checks");
    checkOutput("rst_waitreq", 32'(wrq[0]), 32'd1);
    checkOutput("rst_valid", 32'(vld[0]), 32'd0);
    checkOutput("rst_rdata", rdat0, 32'h0);
    checkOutput("rst_oor", 32'(oor0), 32'd0);
    checkOutput("rst_waitreq_sweep", 32'(wrq[2:1]), 32'd3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_waitreq", 32'(wrq[0]), 32'd1);

    $display("[TB] partial byte writes and default timing");
    doWrite(32'h0, 4'hF, 32'hAABB_CCDD, k);
    doWrite(32'h0, 4'b0011, 32'h1234_5678, k);
    checkOutput("wr_ack_edge", 32'(ackEdge[0] - k), 32'd2);
    checkOutput("wr_ack_cnt", 32'(ackCnt[0]), 32'd1);
    doRead(32'h0, d, k);
    checkOutput("rd_lo16", 32'(d[15:0]), 32'h5678);
    checkOutput("rd_word", d, 32'hAABB_5678);
    checkOutput("rd_ack_edge", 32'(ackEdge[0] - k), 32'd2);
    checkOutput("rd_vld_edge", 32'(vldEdge[0] - k), 32'd4);
    checkOutput("rd_vld_cnt", 32'(vldCnt[0]), 32'd1);
    checkOutput("rd_ack_cnt", 32'(ackCnt[0]), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("rdata_hold", rdat0, 32'hAABB_5678);
    doWrite(32'h0, 4'h0, 32'h0, k);
    checkOutput("be0_ack_cnt", 32'(ackCnt[0]), 32'd1);
    checkRead("be0_noop", 32'h0, 32'hAABB_5678);
    doWrite(32'h0, 4'b1010, 32'h1122_3344, k);
    checkRead("be1010", 32'h0, 32'h11BB_3378);
    checkRead("addr_lowbits", 32'h2, 32'h11BB_3378);

    $display("[TB] fill all words and random readback");
    for (int i = 0; i < 512; i++) doWrite(32'(i * 4), 4'hF, pat(i), k);
    for (int n = 0; n < 10; n++) begin
      idx = int'($urandom_range(511, 0));
      checkRead("rand_rd", 32'(idx * 4) + 32'($urandom_range(3, 0)), pat(idx));
    end
    checkRead("last_word", 32'd2044, pat(511));
    checkRead("addr_2047", 32'd2047, pat(511));
    checkOutput("oor_zero", 32'(oor0), 32'd0);

    $display("[TB] out-of-range accesses");
    doWrite(32'd4096, 4'hF, 32'hCAFE_F00D, k);
    checkOutput("oor_after_wr", 32'(oor0), 32'd1);
    doRead(32'd4096, d, k);
    checkOutput("oor_rdata", d, 32'hDEAD_BEEF);
    checkOutput("oor_ack_edge", 32'(ackEdge[0] - k), 32'd2);
    checkOutput("oor_vld_edge", 32'(vldEdge[0] - k), 32'd4);
    checkOutput("oor_cnt2", 32'(oor0), 32'd2);
    checkRead("ram_addr0", 32'h0, pat(0));
    checkRead("oor_2048", 32'd2048, 32'hDEAD_BEEF);
    checkOutput("oor_cnt3", 32'(oor0), 32'd3);
    doWrite(32'h8000_0000, 4'hF, 32'h0, k);
    checkRead("high_addr_no_alias", 32'h0, pat(0));
    checkOutput("oor_cnt4", 32'(oor0), 32'd4);

    $display("[TB] read and write together");
    clearMon();
    applyStimulus(1'b1, 1'b1, 32'd8, 4'hF, 32'hA5A5_A5A5, k);
    repeat (8) @(negedge clk);
    checkOutput("rw_ack_cnt", 32'(ackCnt[0]), 32'd1);
    checkOutput("rw_no_valid", 32'(vldCnt[0]), 32'd0);
    checkRead("rw_prio", 32'd8, 32'hA5A5_A5A5);

    $display("[TB] request dropped before ack");
    clearMon();
    @(negedge clk);
    wr0 = 1'b1; addrIn = 32'd16; dataIn = 32'h0BAD_CAFE; beIn = 4'hF;
    k = cycle + 1;
    @(negedge clk);
    wr0 = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("pulse_ack_edge", 32'(ackEdge[0] - k), 32'd2);
    checkOutput("pulse_ack_cnt", 32'(ackCnt[0]), 32'd1);
    checkRead("pulse_wr", 32'd16, 32'h0BAD_CAFE);

    $display("[TB] reset during a write");
    clearMon();
    @(negedge clk);
    wr0 = 1'b1; addrIn = 32'd8; dataIn = 32'h7777_7777; beIn = 4'hF;
    @(negedge clk);
    rst = 1'b0; wr0 = 1'b0;
    #1;
    checkOutput("wrrst_waitreq", 32'(wrq[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("wrrst_no_ack", 32'(ackCnt[0]), 32'd0);
    checkRead("wrrst_ram", 32'd8, 32'hA5A5_A5A5);

    $display("[TB] reset during read latency");
    clearMon();
    @(negedge clk);
    rd0 = 1'b1; addrIn = 32'd8; beIn = 4'hF;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rdrst_ack", 32'(wrq[0]), 32'd0);
    @(posedge clk);
    #1 rd0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rdrst_waitreq", 32'(wrq[0]), 32'd1);
    checkOutput("rdrst_valid", 32'(vld[0]), 32'd0);
    checkOutput("rdrst_rdata", rdat0, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("rdrst_waitreq_hold", 32'(wrq[0]), 32'd1);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("rdrst_no_valid", 32'(vldCnt[0]), 32'd0);
    checkOutput("rdrst_oor_cleared", 32'(oor0), 32'd0);
    checkRead("after_rst", 32'd8, 32'hA5A5_A5A5);

    $display("[TB] timing variants");
    pulseSweep(1'b0, 1'b1, 32'd12, 32'h1111_2222, k);
    checkOutput("ws0_wr_ack", 32'(ackEdge[1] - k), 32'd1);
    checkOutput("ws3_wr_ack", 32'(ackEdge[2] - k), 32'd4);
    checkOutput("ws0_wr_ackcnt", 32'(ackCnt[1]), 32'd1);
    checkOutput("ws3_wr_ackcnt", 32'(ackCnt[2]), 32'd1);
    checkOutput("sweep_wr_novld", 32'(vldCnt[1] + vldCnt[2]), 32'd0);
    checkOutput("dut0_idle_in_sweep", 32'(ackCnt[0]), 32'd0);
    pulseSweep(1'b1, 1'b0, 32'd12, 32'h0, k);
    checkOutput("ws0_rd_ack", 32'(ackEdge[1] - k), 32'd1);
    checkOutput("rl1_rd_vld", 32'(vldEdge[1] - k), 32'd2);
    checkOutput("ws3_rd_ack", 32'(ackEdge[2] - k), 32'd4);
    checkOutput("rl4_rd_vld", 32'(vldEdge[2] - k), 32'd8);
    checkOutput("rl1_data", vldData[1], 32'h1111_2222);
    checkOutput("rl4_data", vldData[2], 32'h1111_2222);
    checkOutput("rl1_vcnt", 32'(vldCnt[1]), 32'd1);
    checkOutput("rl4_vcnt", 32'(vldCnt[2]), 32'd1);
    checkOutput("sweep_oor", 32'({oor1, oor2}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
